vga_fb_arb: RTL and testbench
=============================

Name: vga_fb_arb

Overview:
- Framebuffer access arbiter/scheduler feeding the VGA scan-out path.
- Shares one single-port synchronous framebuffer RAM between display prefetch and a pixel writer (draw engine/CPU) on a valid/ready port.
- Keeps a small pixel FIFO ahead of the raster and presents one pixel per cycle while the timing generator's active output is high.
- Sits between vga_ctrl (v_sync, active) and the RAM/DAC.

Parameters:
ADDR_W, 19, framebuffer word address width
DATA_W, 12, pixel width (RGB444)
FRAME_PIXELS, 307200, words per frame (640x480, one word per pixel)
FIFO_DEPTH, 16, prefetch FIFO entries (power of 2)
LOW_WM, 4, urgency watermark for display fetch

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
v_sync  in  1  vertical sync from timing generator, active-low pulse
active  in  1  display active area from timing generator
pix_data  out  DATA_W  pixel to DAC, registered
underflow  out  1  FIFO was empty on an active cycle this frame
wr_valid  in  1  writer request
wr_ready  out  1  writer grant (combinational, may depend on wr_valid)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid exactly 1 cycle after read issue

Behaviour:
- Reset (rst=0, async): pix_data=0, underflow=0, FIFO empty, rd_addr=0, inflight=0, FSM=FS_WAIT. mem_en/mem_we and wr_ready are 0 while rst=0.
- Frame start (fs): registered v_sync=1 and current v_sync=0 (falling edge). On fs: FIFO flushed, rd_addr=0, underflow cleared, FSM->FS_FETCH, no fetch issued that cycle. A read returning the same or next cycle is discarded.
- FSM:
  - FS_WAIT: no fetches; after reset until first fs.
  - FS_FETCH: fetch enabled; issuing address FRAME_PIXELS-1 moves to FS_DONE.
  - FS_DONE: no fetches until next fs.
  - fs from any state goes to FS_FETCH.
- Occupancy: occ = FIFO level + inflight (0 or 1).
- Per-cycle arbitration, at most one RAM op per cycle, in priority order:
  - (1) urgent fetch: FS_FETCH and occ<LOW_WM.
  - (2) write: wr_valid=1.
  - (3) background fetch: FS_FETCH and occ<FIFO_DEPTH.
- Fetch: mem_en=1, mem_we=0, mem_addr=rd_addr, then rd_addr+1. Returned data is pushed next cycle.
- Write:
  - wr_ready=1 exactly when the write is granted; handshake completes on wr_valid&wr_ready.
  - In range: mem_en=1, mem_we=1, address/data passed through.
  - wr_addr>=FRAME_PIXELS: accepted, mem_en=0 (dropped).
- Pop: each cycle with active=1 and not fs, the FIFO pops and pix_data<=head (1-cycle latency from active).
  - active=1 and FIFO empty: pix_data<=0, underflow<=1 (sticky until next fs or reset).
  - active=0: pix_data<=0.
- Push and pop in the same cycle: level unchanged. The FIFO never overflows because fetches are gated by occ.
- fs and active both 1: flush wins; pix_data<=0, underflow not set.
- Reset mid-frame returns to FS_WAIT; display resumes at next fs.

Decomposition:
- Package vga_fb_pkg: fetch state enum (FS_WAIT, FS_FETCH, FS_DONE), FRAME_PIXELS default, pixel type typedef.
- One sub-module, fb_pix_fifo: synchronous FIFO with flush, level output, parameterised depth/width, same clk/rst.

Test Plan:
- Reset: hold rst=0 with wr_valid=1 -> mem_en=0, wr_ready=0, pix_data=0, underflow=0. Release, no fs -> no reads; writes granted every cycle.
- Prefill: fs, active=0, wr_valid=0 -> reads of addr 0..15 on consecutive cycles, then mem_en=0; FIFO level 16.
- Stream: after prefill, active=1 for 640 cycles, RAM[a]=a -> pix_data=0,1,...,639 starting 1 cycle after active rises; underflow=0.
- Contention: wr_valid=1 during active stream -> writes only while occ>=LOW_WM; pix_data sequence unbroken, no underflow. During blanking, writes granted until FIFO needs refill.
- End of frame (FRAME_PIXELS=32): after addr 31 issued -> FS_DONE, no more reads. Out-of-range write addr 40 -> wr_ready=1, mem_en=0.
- Underflow/restart: active=1 right after fs with empty FIFO -> pix_data=0, underflow=1. Next fs -> underflow=0, rd_addr restarts at 0. Async rst mid-FETCH -> outputs zero immediately.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared types and defaults for the framebuffer arbiter.
// Holds the prefetch state encoding and default geometry.
// Pixel type matches the default RGB444 DAC width.
package vga_fb_pkg;

  localparam int DEF_ADDR_W       = 19;
  localparam int DEF_DATA_W       = 12;
  localparam int DEF_FRAME_PIXELS = 307200;

  typedef enum logic [1:0] {
    FS_WAIT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DONE  = 2'd2
  } fetch_state_e;

  typedef logic [DEF_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/vga_fb_arb_if.sv
// Writer request port plus single-port framebuffer RAM bus.
// master = arbiter side (grants writes, drives the RAM), slave = writer/RAM side.
// RAM read data is expected exactly one cycle after a read is issued.
interface vga_fb_arb_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  import vga_fb_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/fb_pix_fifo.sv
// Pixel prefetch FIFO with synchronous flush and level output.
// Latency: pushed word visible at head the cycle after the push.
// No internal backpressure: caller gates pushes by level; pop on empty is ignored.
module fb_pix_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  // Pointer/level update; flush discards everything including a same-cycle push.
  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (level_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  assign empty = (level_q == '0);

endmodule

// File: rtl/vga_fb_arb.sv
// Shares the framebuffer RAM between display prefetch and a pixel writer.
// Latency: pix_data registered, 1 cycle after active; RAM reads land in the FIFO 1 cycle later.
// Backpressure: wr_ready only when no urgent fetch wins; fetches gated by FIFO occupancy.
module vga_fb_arb
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOW_WM       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_sync,
  input  logic              active,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  vga_fb_arb_if.master      bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  fetch_state_e      state_q, state_d;
  logic              vs_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] pix_q, pix_d;
  logic              underflow_q, underflow_d;

  logic [LW-1:0]     level;
  logic [LW:0]       occ;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              fs, fetch_ok, do_fetch, do_write, wr_in_range, pop;

  // Frame start is the falling edge of v_sync; vs_q resets low so reset never fakes one.
  assign fs          = vs_q & ~v_sync;
  assign occ         = {1'b0, level} + {{LW{1'b0}}, inflight_q};
  assign wr_in_range = ({1'b0, bus.wr_addr} < (ADDR_W+1)'(FRAME_PIXELS));

  // One RAM op per cycle: urgent fetch, then write, then background fetch.
  always_comb begin
    fetch_ok = (state_q == FS_FETCH) && !fs;
    do_fetch = 1'b0;
    do_write = 1'b0;
    if (fetch_ok && (occ < (LW+1)'(LOW_WM))) begin
      do_fetch = 1'b1;
    end else if (bus.wr_valid) begin
      do_write = 1'b1;
    end else if (fetch_ok && (occ < (LW+1)'(FIFO_DEPTH))) begin
      do_fetch = 1'b1;
    end
    if (!rst) begin
      do_fetch = 1'b0;
      do_write = 1'b0;
    end
    bus.wr_ready  = do_write;
    bus.mem_en    = do_fetch | (do_write & wr_in_range);
    bus.mem_we    = do_write & wr_in_range;
    bus.mem_addr  = do_write ? bus.wr_addr : rd_addr_q;
    bus.mem_wdata = bus.wr_data;
  end

  // Fetch FSM, read address, pop and pixel/underflow next-state; flush beats everything.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    inflight_d  = do_fetch;
    pix_d       = '0;
    underflow_d = underflow_q;
    pop         = 1'b0;
    if (fs) begin
      state_d     = FS_FETCH;
      rd_addr_d   = '0;
      underflow_d = 1'b0;
    end else begin
      if (do_fetch) begin
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST_ADDR) state_d = FS_DONE;
      end
      if (active) begin
        if (fifo_empty) begin
          underflow_d = 1'b1;
        end else begin
          pop   = 1'b1;
          pix_d = fifo_head;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FS_WAIT;
      vs_q        <= 1'b0;
      rd_addr_q   <= '0;
      inflight_q  <= 1'b0;
      pix_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= v_sync;
      rd_addr_q   <= rd_addr_d;
      inflight_q  <= inflight_d;
      pix_q       <= pix_d;
      underflow_q <= underflow_d;
    end
  end

  // Read data returns the cycle after issue; a flush in that cycle drops it.
  fb_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fs),
    .push  (inflight_q),
    .pop   (pop),
    .wdata (bus.mem_rdata),
    .rdata (fifo_head),
    .level (level),
    .empty (fifo_empty)
  );

  assign pix_data  = pix_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_fb_arb.sv
// Scoreboard bench for vga_fb_arb: stimulus queues expected pixels, reads and writes;
// a negedge monitor pops and compares whenever the DUT shows a pixel or a RAM op.
// Small frame (672 words) so one frame covers stream, contention and end of frame.
module tb_vga_fb_arb;
  import vga_fb_pkg::*;

  localparam int AW = 19;
  localparam int DW = 12;
  localparam int FP = 672;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          v_sync = 1'b1;
  logic          active = 1'b0;
  logic [DW-1:0] pix_data;
  logic          underflow;

  vga_fb_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_fb_arb #(
    .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP), .FIFO_DEPTH(16), .LOW_WM(4)
  ) dut (
    .clk(clk), .rst(rst), .v_sync(v_sync), .active(active),
    .pix_data(pix_data), .underflow(underflow), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_pix[$];
  int exp_rd[$];
  int exp_wa[$];
  int exp_wd[$];
  int p_next = 0;
  bit wr_done = 1'b0;
  logic act_d;
  pixel_t ram [FP];

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // RAM model: synchronous single port, read data one cycle after issue.
  initial for (int a = 0; a < FP; a++) ram[a] = pixel_t'(a);
  always @(posedge clk) begin
    if (bus.mem_en && (bus.mem_addr < AW'(FP))) begin
      if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // A pixel is due on pix_data the cycle after active was high.
  always @(posedge clk or negedge rst) begin
    if (!rst) act_d <= 1'b0;
    else      act_d <= active;
  end

  // Monitor: pop and compare on every presented pixel and RAM op.
  always @(negedge clk) begin
    int e;
    int d;
    if (rst) begin
      if (act_d) begin
        e = (exp_pix.size() > 0) ? exp_pix.pop_front() : -1;
        check("pix", int'(pix_data), e);
      end else begin
        check("pix_idle", int'(pix_data), 0);
      end
      if (bus.mem_en) begin
        if (bus.mem_we) begin
          e = (exp_wa.size() > 0) ? exp_wa.pop_front() : -1;
          d = (exp_wd.size() > 0) ? exp_wd.pop_front() : -1;
          check("wr_addr", int'(bus.mem_addr), e);
          check("wr_data", int'(bus.mem_wdata), d);
        end else begin
          e = (exp_rd.size() > 0) ? exp_rd.pop_front() : -1;
          check("rd_addr", int'(bus.mem_addr), e);
        end
      end
    end
  end

  task automatic refill_rd();
    exp_rd.delete();
    for (int a = 0; a < FP; a++) exp_rd.push_back(a);
  endtask

  task automatic do_write(input int a, input int d);
    int n = 0;
    exp_wa.push_back(a);
    exp_wd.push_back(d);
    bus.wr_addr  = AW'(a);
    bus.wr_data  = DW'(d);
    bus.wr_valid = 1'b1;
    @(negedge clk);
    while (!bus.wr_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("wr_grant_wait", int'(bus.wr_ready), 1);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic run_active(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      active = 1'b1;
      exp_pix.push_back(p_next);
      p_next++;
    end
    @(posedge clk); #1;
    active = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(100);
    bus.wr_data  = DW'(100);

    // Reset holds everything quiet even with a pending write.
    repeat (3) @(negedge clk);
    check("rst_wr_ready", int'(bus.wr_ready), 0);
    check("rst_mem_en", int'(bus.mem_en), 0);
    check("rst_pix", int'(pix_data), 0);
    check("rst_underflow", int'(underflow), 0);

    // Before the first frame start: writes granted every cycle, no reads.
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_wa.push_back(100 + k);
      exp_wd.push_back(100 + k);
      bus.wr_addr = AW'(100 + k);
      bus.wr_data = DW'(100 + k);
      @(negedge clk);
      check("wait_wr_ready", int'(bus.wr_ready), 1);
      check("wait_mem_we", int'(bus.mem_we), 1);
    end
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;
    idle(5);
    check("wait_no_read", int'(bus.mem_en), 0);

    // Prefill: no fetch on the fs cycle, then 16 back-to-back reads, then full.
    @(posedge clk); #1;
    refill_rd();
    v_sync = 1'b0;
    @(negedge clk);
    check("fs_no_fetch", int'(bus.mem_en), 0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 3) v_sync = 1'b1;
      @(negedge clk);
      check("prefill_rd_en", int'(bus.mem_en), 1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("prefill_full", int'(bus.mem_en), 0);
    check("prefill_count", FP - exp_rd.size(), 16);

    // Stream one line alone, then one line against a continuous writer.
    p_next = 0;
    run_active(320);
    idle(20);
    fork
      begin
        for (int k = 0; k < 30; k++) do_write(600 + k, 600 + k);
        wr_done = 1'b1;
      end
    join_none
    run_active(320);
    check("stream_underflow", int'(underflow), 0);
    for (int n = 0; n < 3000 && !wr_done; n++) @(posedge clk);
    #1;
    check("writer_done", int'(wr_done), 1);
    idle(30);

    // Remaining pixels of the frame; afterwards the fetcher must stop.
    run_active(32);
    idle(5);
    check("frame_reads_left", exp_rd.size(), 0);
    check("done_no_fetch", int'(bus.mem_en), 0);
    check("frame_underflow", int'(underflow), 0);

    // Out-of-range write is accepted but never reaches the RAM.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(FP + 8);
    bus.wr_data  = DW'(5);
    @(negedge clk);
    check("oor_wr_ready", int'(bus.wr_ready), 1);
    check("oor_mem_en", int'(bus.mem_en), 0);
    @(posedge clk); #1;
    bus.wr_valid = 1'b0;

    // Active past the end of the frame drains an empty FIFO.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      active = 1'b1;
      exp_pix.push_back(0);
    end
    @(posedge clk); #1;
    active = 1'b0;
    @(negedge clk);
    check("eof_underflow", int'(underflow), 1);

    // fs together with active: flush wins, then underflow on the empty FIFO.
    @(posedge clk); #1;
    refill_rd();
    v_sync = 1'b0;
    active = 1'b1;
    exp_pix.push_back(0);
    @(posedge clk); #1;
    v_sync = 1'b1;
    exp_pix.push_back(0);
    @(negedge clk);
    check("fs_clears_underflow", int'(underflow), 0);
    @(posedge clk); #1;
    exp_pix.push_back(0);
    @(negedge clk);
    check("empty_sets_underflow", int'(underflow), 1);
    for (int k = 3; k < 40; k++) begin
      @(posedge clk); #1;
      exp_pix.push_back(k - 3);
    end

    // Asynchronous reset mid-fetch clears outputs without waiting for a clock.
    @(posedge clk); #3;
    rst = 1'b0;
    active = 1'b0;
    exp_pix.delete();
    exp_rd.delete();
    #1;
    check("arst_pix", int'(pix_data), 0);
    check("arst_underflow", int'(underflow), 0);
    check("arst_mem_en", int'(bus.mem_en), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", int'(bus.mem_en), 0);

    // Display resumes from address 0 at the next frame start.
    @(posedge clk); #1;
    refill_rd();
    v_sync = 1'b0;
    @(posedge clk); #1;
    v_sync = 1'b1;
    idle(20);
    p_next = 0;
    run_active(16);
    idle(3);
    check("pix_queue_drained", exp_pix.size(), 0);
    check("restart_underflow", int'(underflow), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
